// File: rtl/combo_lock_ctrl.sv
// ---------------------------------------------------------------------------
// combo_lock_ctrl
//   Keypad combination-lock controller. One-hot key presses from a debounced,
//   synchronised keypad are matched in order against a CODE_LEN-digit code.
//   The lock opens only when tryopen is raised after a complete, correct
//   entry. Adds an idle timeout during entry, consecutive failed-attempt
//   counting, and a timed lockout after MAX_FAILS failures.
//
//   Ports
//     clk         system clock, everything on the rising edge
//     rst         synchronous active-high reset; code is captured while high
//     code        CODE_LEN digits of DW bits, digit 0 (entered first) at LSBs
//     keypad      key levels, bit k high while key k is held
//     tryopen     open request level
//     unlock      lock released (registered)
//     fail        one-cycle pulse per failed attempt
//     locked_out  high while in lockout
//     progress    digits matched so far
//     fail_cnt    consecutive failed attempts
//
//   Build option
//     CODE_OFFSET_EN  when defined, dial-overshoot compensation is applied to
//                     the code as it is captured: even digits are expected
//                     one lower (0 wraps to KEYS-1), odd digits one higher
//                     (KEYS-1 wraps to 0). Undefined: digits used as given.
// ---------------------------------------------------------------------------
module combo_lock_ctrl #(
   parameter  int CODE_LEN    = 6,
   parameter  int KEYS        = 10,
   parameter  int MAX_FAILS   = 3,
   parameter  int TIMEOUT_CYC = 500,
   parameter  int LOCKOUT_CYC = 1000,
   localparam int DW          = $clog2(KEYS),
   localparam int PW          = $clog2(CODE_LEN + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CODE_LEN*DW-1:0] code,
   input  logic [KEYS-1:0]        keypad,
   input  logic                   tryopen,
   output logic                   unlock,
   output logic                   fail,
   output logic                   locked_out,
   output logic [PW-1:0]          progress,
   output logic [3:0]             fail_cnt
);

   localparam int             TMAX    = (TIMEOUT_CYC > LOCKOUT_CYC) ? TIMEOUT_CYC : LOCKOUT_CYC;
   localparam int             TW      = $clog2(TMAX + 1);
   localparam logic [DW:0]    KEYS_W  = (DW + 1)'(KEYS);
   localparam logic [DW-1:0]  KEY_TOP = DW'(KEYS - 1);

   typedef enum logic [2:0] {
      IDLE,
      ENTER,
      ARMED,
      OPEN,
      LOCKOUT
   } state_t;

   state_t                  stateQ;
   state_t                  nextState;
   logic [CODE_LEN*DW-1:0]  codeQ;
   logic [KEYS-1:0]         kpPrev;
   logic                    tryPrev;
   logic [TW-1:0]           timerQ;

   logic                    pressEv;
   logic                    oneHot;
   logic [DW-1:0]           keyIdx;
   logic [DW-1:0]           expDigit;
   logic                    digitOk;
   logic                    match;
   logic                    mismatch;
   logic                    tryRise;
   logic                    timeoutHit;
   logic                    lockDone;
   logic [TW-1:0]           timerInc;
   logic [PW-1:0]           progInc;
   logic [3:0]              failInc;

   logic [TW-1:0]           timerD;
   logic [PW-1:0]           progressD;
   logic [3:0]              failCntD;
   logic                    failD;
   logic                    doFail;
   logic                    unlockD;
   logic                    lockedOutD;

   // The code is latched only while reset is held. With overshoot
   // compensation enabled the expected digits are precomputed here so the
   // matcher never has to know about the offset. Digits that are already out
   // of range are left alone so they still never match.
   function automatic logic [CODE_LEN*DW-1:0] captureCode(input logic [CODE_LEN*DW-1:0] raw);
      logic [CODE_LEN*DW-1:0] res;
      res = raw;
`ifdef CODE_OFFSET_EN
      for (int i = 0; i < CODE_LEN; i++) begin
         logic [DW-1:0] d;
         d = raw[i*DW +: DW];
         if ({1'b0, d} < KEYS_W) begin
            if ((i % 2) == 0)
               res[i*DW +: DW] = (d == '0) ? KEY_TOP : d - DW'(1);
            else
               res[i*DW +: DW] = (d == KEY_TOP) ? '0 : d + DW'(1);
         end
      end
`endif
      return res;
   endfunction

   // Index of the highest set key. Only meaningful when the press is one-hot;
   // multi-hot presses are rejected separately regardless of this value.
   always_comb begin
      keyIdx = '0;
      for (int k = 0; k < KEYS; k++) begin
         if (keypad[k])
            keyIdx = DW'(k);
      end
   end

   // Digit the keypad must produce next, selected by how far entry has got.
   // progress equals CODE_LEN only in ARMED/OPEN, where no digit is expected.
   always_comb begin
      expDigit = '0;
      for (int i = 0; i < CODE_LEN; i++) begin
         if (progress == PW'(i))
            expDigit = codeQ[i*DW +: DW];
      end
   end

   // Event decode. A press is a transition from no key to some key, so held
   // keys and releases are silent. The timer helpers saturate rather than wrap.
   always_comb begin
      pressEv    = (keypad != '0) && (kpPrev == '0);
      oneHot     = (keypad & (keypad - KEYS'(1))) == '0;
      digitOk    = oneHot && ({1'b0, expDigit} < KEYS_W) && (keyIdx == expDigit);
      match      = pressEv && digitOk;
      mismatch   = pressEv && !digitOk;
      tryRise    = tryopen && !tryPrev;
      timeoutHit = (timerQ == TW'(TIMEOUT_CYC - 1));
      lockDone   = (timerQ == TW'(LOCKOUT_CYC - 1));
      timerInc   = (timerQ == '1) ? timerQ : timerQ + TW'(1);
      progInc    = progress + PW'(1);
      failInc    = fail_cnt + 4'd1;
   end

   // Next-state logic. Every transition is decided from the inputs sampled on
   // the current edge. Failed attempts from any state funnel through doFail so
   // a press and a tryopen rise on the same edge give only one fail pulse.
   // In ARMED a press takes priority over tryopen: any extra key after the
   // full code voids the entry.
   always_comb begin
      nextState = stateQ;
      timerD    = timerQ;
      progressD = progress;
      failCntD  = fail_cnt;
      failD     = 1'b0;
      doFail    = 1'b0;

      unique case (stateQ)
         IDLE: begin
            timerD    = '0;
            progressD = '0;
            if (match) begin
               progressD = PW'(1);
               nextState = (CODE_LEN == 1) ? ARMED : ENTER;
            end else if (mismatch) begin
               doFail = 1'b1;
            end
         end

         ENTER: begin
            if (mismatch || tryRise) begin
               doFail = 1'b1;
            end else if (match) begin
               progressD = progInc;
               timerD    = '0;
               if (progInc == PW'(CODE_LEN))
                  nextState = ARMED;
            end else if (timeoutHit) begin
               nextState = IDLE;
               progressD = '0;
               timerD    = '0;
            end else begin
               timerD = timerInc;
            end
         end

         ARMED: begin
            if (pressEv) begin
               doFail = 1'b1;
            end else if (tryopen) begin
               nextState = OPEN;
               failCntD  = '0;
               timerD    = '0;
            end else if (timeoutHit) begin
               nextState = IDLE;
               progressD = '0;
               timerD    = '0;
            end else begin
               timerD = timerInc;
            end
         end

         OPEN: begin
            timerD = '0;
            if (!tryopen) begin
               nextState = IDLE;
               progressD = '0;
            end
         end

         LOCKOUT: begin
            if (lockDone) begin
               nextState = IDLE;
               failCntD  = '0;
               timerD    = '0;
            end else begin
               timerD = timerInc;
            end
         end

         default: begin
            nextState = IDLE;
            timerD    = '0;
            progressD = '0;
         end
      endcase

      if (doFail) begin
         failD     = 1'b1;
         progressD = '0;
         timerD    = '0;
         failCntD  = failInc;
         nextState = (failInc >= 4'(MAX_FAILS)) ? LOCKOUT : IDLE;
      end
   end

   // Registered state-dependent outputs are derived from the state being
   // entered, so they change on the same edge as the transition.
   always_comb begin
      unlockD    = (nextState == OPEN);
      lockedOutD = (nextState == LOCKOUT);
   end

   // State and output registers. The keypad and tryopen history registers
   // keep sampling during reset, so a key or request held across reset is
   // seen as already held and produces no event until released and pressed
   // again. With nothing held they read zero after reset.
   always_ff @(posedge clk) begin
      kpPrev  <= keypad;
      tryPrev <= tryopen;
      if (rst) begin
         stateQ     <= IDLE;
         codeQ      <= captureCode(code);
         timerQ     <= '0;
         progress   <= '0;
         fail_cnt   <= '0;
         fail       <= 1'b0;
         unlock     <= 1'b0;
         locked_out <= 1'b0;
      end else begin
         stateQ     <= nextState;
         timerQ     <= timerD;
         progress   <= progressD;
         fail_cnt   <= failCntD;
         fail       <= failD;
         unlock     <= unlockD;
         locked_out <= lockedOutD;
      end
   end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_combo_lock_ctrl
//   Self-checking bench for combo_lock_ctrl with default parameters. Each
//   scenario task builds a list of single-cycle steps; checked steps push the
//   expected output word into a scoreboard when driven and pop it after the
//   following edge. Output word = {unlock, fail, locked_out, progress, fail_cnt}.
// ---------------------------------------------------------------------------
module tb_combo_lock_ctrl;

   localparam int CODE_LEN = 6;
   localparam int KEYS     = 10;
   localparam int DW       = 4;

`ifdef CODE_OFFSET_EN
   localparam logic [23:0] BASE_CODE = 24'h563412;
`else
   localparam logic [23:0] BASE_CODE = 24'h654321;
`endif

   logic                   clk = 1'b0;
   logic                   rst;
   logic [CODE_LEN*DW-1:0] code;
   logic [KEYS-1:0]        keypad;
   logic                   tryopen;
   logic                   unlock;
   logic                   fail;
   logic                   locked_out;
   logic [2:0]             progress;
   logic [3:0]             fail_cnt;

   typedef struct {
      logic [KEYS-1:0] kp;
      logic            tr;
      logic            rs;
      bit              chk;
      logic [9:0]      ex;
      string           tag;
   } step_t;

   typedef struct {
      logic [9:0] v;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   nChecks = 0;
   int   nPass   = 0;

   combo_lock_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .code       (code),
      .keypad     (keypad),
      .tryopen    (tryopen),
      .unlock     (unlock),
      .fail       (fail),
      .locked_out (locked_out),
      .progress   (progress),
      .fail_cnt   (fail_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] pk(input logic u, input logic f, input logic l,
                                     input logic [2:0] p, input logic [3:0] c);
      return {u, f, l, p, c};
   endfunction

   function automatic logic [KEYS-1:0] key(input int k);
      logic [KEYS-1:0] one;
      one = KEYS'(1);
      return one << k;
   endfunction

   function automatic step_t mk(input logic [KEYS-1:0] kp, input logic tr, input logic rs,
                                input bit chk, input logic [9:0] ex, input string tag);
      step_t s;
      s.kp = kp; s.tr = tr; s.rs = rs; s.chk = chk; s.ex = ex; s.tag = tag;
      return s;
   endfunction

   // Reset clears everything and the first idle cycle after it stays quiet.
   task automatic test_reset();
      step_t q[$];
      exp_t  e;
      logic [9:0] obs;
      code = BASE_CODE;
      q.push_back(mk('0, 1'b0, 1'b1, 1'b1, pk(0,0,0,0,0), "reset_state"));
      q.push_back(mk('0, 1'b0, 1'b0, 1'b1, pk(0,0,0,0,0), "reset_idle"));
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         keypad = q[i].kp; tryopen = q[i].tr; rst = q[i].rs;
         if (q[i].chk) sb.push_back('{q[i].ex, q[i].tag});
         @(posedge clk); #1;
         if (q[i].chk) begin
            e = sb.pop_front(); obs = {unlock, fail, locked_out, progress, fail_cnt}; nChecks++;
            if (obs !== e.v)
               $display("[TB] FAIL %s: got u/f/l/p/c=%0b/%0b/%0b/%0d/%0d required %0b/%0b/%0b/%0d/%0d",
                        e.tag, obs[9], obs[8], obs[7], obs[6:4], obs[3:0], e.v[9], e.v[8], e.v[7], e.v[6:4], e.v[3:0]);
            else nPass++;
         end
      end
   endtask

   // Correct code with releases between digits, open, then release tryopen.
   task automatic test_unlock();
      step_t q[$];
      exp_t  e;
      logic [9:0] obs;
      code = BASE_CODE;
      q.push_back(mk('0, 1'b0, 1'b1, 1'b0, '0, "rst"));
      for (int d = 0; d < 6; d++) begin
         q.push_back(mk(key(d+1), 1'b0, 1'b0, 1'b1, pk(0,0,0,3'(d+1),0), $sformatf("unlock_press%0d", d)));
         q.push_back(mk('0,       1'b0, 1'b0, 1'b1, pk(0,0,0,3'(d+1),0), $sformatf("unlock_rel%0d", d)));
      end
      q.push_back(mk('0, 1'b1, 1'b0, 1'b1, pk(1,0,0,6,0), "unlock_open"));
      q.push_back(mk('0, 1'b1, 1'b0, 1'b1, pk(1,0,0,6,0), "unlock_hold"));
      q.push_back(mk('0, 1'b0, 1'b0, 1'b1, pk(0,0,0,0,0), "unlock_drop"));
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         keypad = q[i].kp; tryopen = q[i].tr; rst = q[i].rs;
         if (q[i].chk) sb.push_back('{q[i].ex, q[i].tag});
         @(posedge clk); #1;
         if (q[i].chk) begin
            e = sb.pop_front(); obs = {unlock, fail, locked_out, progress, fail_cnt}; nChecks++;
            if (obs !== e.v)
               $display("[TB] FAIL %s: got u/f/l/p/c=%0b/%0b/%0b/%0d/%0d required %0b/%0b/%0b/%0d/%0d",
                        e.tag, obs[9], obs[8], obs[7], obs[6:4], obs[3:0], e.v[9], e.v[8], e.v[7], e.v[6:4], e.v[3:0]);
            else nPass++;
         end
      end
   endtask

   // Wrong third digit, then a two-key press that includes the right digit.
   task automatic test_wrong_digit();
      step_t q[$];
      exp_t  e;
      logic [9:0] obs;
      code = BASE_CODE;
      q.push_back(mk('0, 1'b0, 1'b1, 1'b0, '0, "rst"));
      q.push_back(mk(key(1), 1'b0, 1'b0, 1'b1, pk(0,0,0,1,0), "wrong_p1"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b0, '0, "rel"));
      q.push_back(mk(key(2), 1'b0, 1'b0, 1'b1, pk(0,0,0,2,0), "wrong_p2"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b0, '0, "rel"));
      q.push_back(mk(key(7), 1'b0, 1'b0, 1'b1, pk(0,1,0,0,1), "wrong_p7_fail"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b1, pk(0,0,0,0,1), "wrong_pulse_end"));
      q.push_back(mk(10'h003, 1'b0, 1'b0, 1'b1, pk(0,1,0,0,2), "multihot_fail"));
      q.push_back(mk(10'h003, 1'b0, 1'b0, 1'b1, pk(0,0,0,0,2), "multihot_held"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b1, pk(0,0,0,0,2), "multihot_rel"));
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         keypad = q[i].kp; tryopen = q[i].tr; rst = q[i].rs;
         if (q[i].chk) sb.push_back('{q[i].ex, q[i].tag});
         @(posedge clk); #1;
         if (q[i].chk) begin
            e = sb.pop_front(); obs = {unlock, fail, locked_out, progress, fail_cnt}; nChecks++;
            if (obs !== e.v)
               $display("[TB] FAIL %s: got u/f/l/p/c=%0b/%0b/%0b/%0d/%0d required %0b/%0b/%0b/%0d/%0d",
                        e.tag, obs[9], obs[8], obs[7], obs[6:4], obs[3:0], e.v[9], e.v[8], e.v[7], e.v[6:4], e.v[3:0]);
            else nPass++;
         end
      end
   endtask

   // tryopen rising mid-entry fails; a correct press together with a tryopen
   // rise gives a single failed attempt.
   task automatic test_tryopen_enter();
      step_t q[$];
      exp_t  e;
      logic [9:0] obs;
      code = BASE_CODE;
      q.push_back(mk('0, 1'b0, 1'b1, 1'b0, '0, "rst"));
      q.push_back(mk(key(1), 1'b0, 1'b0, 1'b1, pk(0,0,0,1,0), "try_p1"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b0, '0, "rel"));
      q.push_back(mk('0,     1'b1, 1'b0, 1'b1, pk(0,1,0,0,1), "try_rise_fail"));
      q.push_back(mk('0,     1'b1, 1'b0, 1'b1, pk(0,0,0,0,1), "try_idle_ignored"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b0, '0, "drop"));
      q.push_back(mk(key(1), 1'b0, 1'b0, 1'b1, pk(0,0,0,1,1), "try_p1b"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b0, '0, "rel"));
      q.push_back(mk(key(2), 1'b1, 1'b0, 1'b1, pk(0,1,0,0,2), "press_and_rise_fail"));
      q.push_back(mk(key(2), 1'b1, 1'b0, 1'b1, pk(0,0,0,0,2), "single_pulse"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b0, '0, "rel"));
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         keypad = q[i].kp; tryopen = q[i].tr; rst = q[i].rs;
         if (q[i].chk) sb.push_back('{q[i].ex, q[i].tag});
         @(posedge clk); #1;
         if (q[i].chk) begin
            e = sb.pop_front(); obs = {unlock, fail, locked_out, progress, fail_cnt}; nChecks++;
            if (obs !== e.v)
               $display("[TB] FAIL %s: got u/f/l/p/c=%0b/%0b/%0b/%0d/%0d required %0b/%0b/%0b/%0d/%0d",
                        e.tag, obs[9], obs[8], obs[7], obs[6:4], obs[3:0], e.v[9], e.v[8], e.v[7], e.v[6:4], e.v[3:0]);
            else nPass++;
         end
      end
   endtask

   // Three failures lock out for 1000 cycles; the correct code is ignored.
   task automatic test_lockout();
      step_t q[$];
      exp_t  e;
      logic [9:0] obs;
      code = BASE_CODE;
      q.push_back(mk('0, 1'b0, 1'b1, 1'b0, '0, "rst"));
      q.push_back(mk(key(9), 1'b0, 1'b0, 1'b1, pk(0,1,0,0,1), "lock_f1"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b0, '0, "rel"));
      q.push_back(mk(key(9), 1'b0, 1'b0, 1'b1, pk(0,1,0,0,2), "lock_f2"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b0, '0, "rel"));
      q.push_back(mk(key(9), 1'b0, 1'b0, 1'b1, pk(0,1,1,0,3), "lock_enter"));
      for (int d = 0; d < 6; d++) begin
         q.push_back(mk(key(d+1), 1'b0, 1'b0, 1'b1, pk(0,0,1,0,3), $sformatf("lock_ign_p%0d", d)));
         q.push_back(mk('0,       1'b0, 1'b0, 1'b0, '0, "rel"));
      end
      q.push_back(mk('0, 1'b1, 1'b0, 1'b1, pk(0,0,1,0,3), "lock_ign_try"));
      q.push_back(mk('0, 1'b1, 1'b0, 1'b1, pk(0,0,1,0,3), "lock_ign_try2"));
      for (int k = 15; k < 999; k++)
         q.push_back(mk('0, 1'b0, 1'b0, 1'b0, '0, "wait"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b1, pk(0,0,1,0,3), "lock_last_cycle"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b1, pk(0,0,0,0,0), "lock_exit"));
      q.push_back(mk(key(1), 1'b0, 1'b0, 1'b1, pk(0,0,0,1,0), "lock_after_p1"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b0, '0, "rel"));
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         keypad = q[i].kp; tryopen = q[i].tr; rst = q[i].rs;
         if (q[i].chk) sb.push_back('{q[i].ex, q[i].tag});
         @(posedge clk); #1;
         if (q[i].chk) begin
            e = sb.pop_front(); obs = {unlock, fail, locked_out, progress, fail_cnt}; nChecks++;
            if (obs !== e.v)
               $display("[TB] FAIL %s: got u/f/l/p/c=%0b/%0b/%0b/%0d/%0d required %0b/%0b/%0b/%0d/%0d",
                        e.tag, obs[9], obs[8], obs[7], obs[6:4], obs[3:0], e.v[9], e.v[8], e.v[7], e.v[6:4], e.v[3:0]);
            else nPass++;
         end
      end
   endtask

   // Entry timeout after 500 idle edges, no fail pulse; presses on the
   // 499th and on the 500th idle edge are both accepted.
   task automatic test_timeout();
      step_t q[$];
      exp_t  e;
      logic [9:0] obs;
      code = BASE_CODE;
      q.push_back(mk('0, 1'b0, 1'b1, 1'b0, '0, "rst"));
      q.push_back(mk(key(1), 1'b0, 1'b0, 1'b1, pk(0,0,0,1,0), "to_p1"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b0, '0, "rel"));
      q.push_back(mk(key(2), 1'b0, 1'b0, 1'b1, pk(0,0,0,2,0), "to_p2"));
      for (int j = 1; j < 499; j++)
         q.push_back(mk('0, 1'b0, 1'b0, 1'b0, '0, "wait"));
      q.push_back(mk('0, 1'b0, 1'b0, 1'b1, pk(0,0,0,2,0), "to_idle499"));
      q.push_back(mk('0, 1'b0, 1'b0, 1'b1, pk(0,0,0,0,0), "to_expire"));
      q.push_back(mk('0, 1'b0, 1'b0, 1'b1, pk(0,0,0,0,0), "to_no_pulse"));
      q.push_back(mk(key(1), 1'b0, 1'b0, 1'b1, pk(0,0,0,1,0), "to_b_p1"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b0, '0, "rel"));
      q.push_back(mk(key(2), 1'b0, 1'b0, 1'b1, pk(0,0,0,2,0), "to_b_p2"));
      for (int j = 1; j < 499; j++)
         q.push_back(mk('0, 1'b0, 1'b0, 1'b0, '0, "wait"));
      q.push_back(mk(key(3), 1'b0, 1'b0, 1'b1, pk(0,0,0,3,0), "to_press_499"));
      for (int j = 1; j < 500; j++)
         q.push_back(mk('0, 1'b0, 1'b0, 1'b0, '0, "wait"));
      q.push_back(mk(key(4), 1'b0, 1'b0, 1'b1, pk(0,0,0,4,0), "to_press_wins_500"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b1, pk(0,0,0,4,0), "to_after_500"));
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         keypad = q[i].kp; tryopen = q[i].tr; rst = q[i].rs;
         if (q[i].chk) sb.push_back('{q[i].ex, q[i].tag});
         @(posedge clk); #1;
         if (q[i].chk) begin
            e = sb.pop_front(); obs = {unlock, fail, locked_out, progress, fail_cnt}; nChecks++;
            if (obs !== e.v)
               $display("[TB] FAIL %s: got u/f/l/p/c=%0b/%0b/%0b/%0d/%0d required %0b/%0b/%0b/%0d/%0d",
                        e.tag, obs[9], obs[8], obs[7], obs[6:4], obs[3:0], e.v[9], e.v[8], e.v[7], e.v[6:4], e.v[3:0]);
            else nPass++;
         end
      end
   endtask

   // Press in ARMED fails; a second full entry opens and clears fail_cnt;
   // presses while open are ignored.
   task automatic test_back_to_back();
      step_t q[$];
      exp_t  e;
      logic [9:0] obs;
      code = BASE_CODE;
      q.push_back(mk('0, 1'b0, 1'b1, 1'b0, '0, "rst"));
      for (int d = 0; d < 6; d++) begin
         q.push_back(mk(key(d+1), 1'b0, 1'b0, 1'b1, pk(0,0,0,3'(d+1),0), $sformatf("b2b_a%0d", d)));
         q.push_back(mk('0,       1'b0, 1'b0, 1'b0, '0, "rel"));
      end
      q.push_back(mk(key(8), 1'b0, 1'b0, 1'b1, pk(0,1,0,0,1), "armed_press_fail"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b0, '0, "rel"));
      for (int d = 0; d < 6; d++) begin
         q.push_back(mk(key(d+1), 1'b0, 1'b0, 1'b1, pk(0,0,0,3'(d+1),1), $sformatf("b2b_b%0d", d)));
         q.push_back(mk('0,       1'b0, 1'b0, 1'b0, '0, "rel"));
      end
      q.push_back(mk('0,     1'b1, 1'b0, 1'b1, pk(1,0,0,6,0), "b2b_open_clears"));
      q.push_back(mk(key(3), 1'b1, 1'b0, 1'b1, pk(1,0,0,6,0), "open_press_ign"));
      q.push_back(mk('0,     1'b1, 1'b0, 1'b1, pk(1,0,0,6,0), "open_rel"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b1, pk(0,0,0,0,0), "b2b_close"));
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         keypad = q[i].kp; tryopen = q[i].tr; rst = q[i].rs;
         if (q[i].chk) sb.push_back('{q[i].ex, q[i].tag});
         @(posedge clk); #1;
         if (q[i].chk) begin
            e = sb.pop_front(); obs = {unlock, fail, locked_out, progress, fail_cnt}; nChecks++;
            if (obs !== e.v)
               $display("[TB] FAIL %s: got u/f/l/p/c=%0b/%0b/%0b/%0d/%0d required %0b/%0b/%0b/%0d/%0d",
                        e.tag, obs[9], obs[8], obs[7], obs[6:4], obs[3:0], e.v[9], e.v[8], e.v[7], e.v[6:4], e.v[3:0]);
            else nPass++;
         end
      end
   endtask

   // Reset while open drops unlock; a key held across reset is not a press.
   task automatic test_reset_midop();
      step_t q[$];
      exp_t  e;
      logic [9:0] obs;
      code = BASE_CODE;
      q.push_back(mk('0, 1'b0, 1'b1, 1'b0, '0, "rst"));
      for (int d = 0; d < 6; d++) begin
         q.push_back(mk(key(d+1), 1'b0, 1'b0, 1'b0, '0, "entry"));
         q.push_back(mk('0,       1'b0, 1'b0, 1'b0, '0, "rel"));
      end
      q.push_back(mk('0,     1'b1, 1'b0, 1'b1, pk(1,0,0,6,0), "mid_open"));
      q.push_back(mk('0,     1'b1, 1'b1, 1'b1, pk(0,0,0,0,0), "mid_rst_unlock"));
      q.push_back(mk(key(1), 1'b0, 1'b1, 1'b1, pk(0,0,0,0,0), "mid_rst_key"));
      q.push_back(mk(key(1), 1'b0, 1'b0, 1'b1, pk(0,0,0,0,0), "held_no_event"));
      q.push_back(mk(key(1), 1'b0, 1'b0, 1'b1, pk(0,0,0,0,0), "held_no_event2"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b1, pk(0,0,0,0,0), "held_release"));
      q.push_back(mk(key(1), 1'b0, 1'b0, 1'b1, pk(0,0,0,1,0), "repress"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b0, '0, "rel"));
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         keypad = q[i].kp; tryopen = q[i].tr; rst = q[i].rs;
         if (q[i].chk) sb.push_back('{q[i].ex, q[i].tag});
         @(posedge clk); #1;
         if (q[i].chk) begin
            e = sb.pop_front(); obs = {unlock, fail, locked_out, progress, fail_cnt}; nChecks++;
            if (obs !== e.v)
               $display("[TB] FAIL %s: got u/f/l/p/c=%0b/%0b/%0b/%0d/%0d required %0b/%0b/%0b/%0d/%0d",
                        e.tag, obs[9], obs[8], obs[7], obs[6:4], obs[3:0], e.v[9], e.v[8], e.v[7], e.v[6:4], e.v[3:0]);
            else nPass++;
         end
      end
   endtask

`ifdef CODE_OFFSET_EN
   // Code 0,9,3,4,5,6 is entered as 9,0,2,5,4,7; the literal digits fail.
   task automatic test_offset();
      step_t q[$];
      exp_t  e;
      logic [9:0] obs;
      int   seq [6] = '{9, 0, 2, 5, 4, 7};
      code = 24'h654390;
      q.push_back(mk('0, 1'b0, 1'b1, 1'b0, '0, "rst"));
      for (int d = 0; d < 6; d++) begin
         q.push_back(mk(key(seq[d]), 1'b0, 1'b0, 1'b1, pk(0,0,0,3'(d+1),0), $sformatf("ofs_p%0d", d)));
         q.push_back(mk('0,          1'b0, 1'b0, 1'b0, '0, "rel"));
      end
      q.push_back(mk('0,     1'b1, 1'b0, 1'b1, pk(1,0,0,6,0), "ofs_open"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b1, pk(0,0,0,0,0), "ofs_close"));
      q.push_back(mk(key(0), 1'b0, 1'b0, 1'b1, pk(0,1,0,0,1), "ofs_literal_fail"));
      q.push_back(mk('0,     1'b0, 1'b0, 1'b0, '0, "rel"));
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         keypad = q[i].kp; tryopen = q[i].tr; rst = q[i].rs;
         if (q[i].chk) sb.push_back('{q[i].ex, q[i].tag});
         @(posedge clk); #1;
         if (q[i].chk) begin
            e = sb.pop_front(); obs = {unlock, fail, locked_out, progress, fail_cnt}; nChecks++;
            if (obs !== e.v)
               $display("[TB] FAIL %s: got u/f/l/p/c=%0b/%0b/%0b/%0d/%0d required %0b/%0b/%0b/%0d/%0d",
                        e.tag, obs[9], obs[8], obs[7], obs[6:4], obs[3:0], e.v[9], e.v[8], e.v[7], e.v[6:4], e.v[3:0]);
            else nPass++;
         end
      end
   endtask
`endif

   initial begin
      rst     = 1'b1;
      keypad  = '0;
      tryopen = 1'b0;
      code    = BASE_CODE;
      $display("[TB] combo_lock_ctrl bench start");
      test_reset();
      test_unlock();
      test_wrong_digit();
      test_tryopen_enter();
      test_lockout();
      test_timeout();
      test_back_to_back();
      test_reset_midop();
`ifdef CODE_OFFSET_EN
      test_offset();
`endif
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
